cordic_atan2: RTL

CORDIC_ATAN2 -- requirements
Module: cordic_atan2

---
 rtl/cordic_pkg.sv | 44 ++++
 rtl/cordic_microrot.sv | 44 ++++
 rtl/cordic_atan2.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cordic_pkg
// Brief    : Shared constants, arctangent table and FSM state type for the
//            CORDIC family of blocks. Angles are Q1.2.13 radians.
// Revision : 1.0 - initial release
// ============================================================================
package cordic_pkg;

    // Default number of vectoring micro-rotations
    localparam int ITER_DEFAULT = 14;

    // Angle accumulator width: holds +/-pi plus the full table sum with margin
    localparam int ZW = 18;

    // Angle and gain constants
    localparam int PI      = 25736;
    localparam int HALF_PI = 12868;
    localparam int K_INV   = 9949;

    // atan(2^-i) in Q1.2.13, i = 0..13
    localparam int ATAN_LEN = 14;
    localparam int ATAN [ATAN_LEN] = '{6434, 3798, 2007, 1019, 511, 256, 128,
                                       64, 32, 16, 8, 4, 2, 1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROT   = 2'd1,
        SCALE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Table lookup by runtime index; out-of-range indices return zero
    function automatic logic signed [ZW-1:0] atan_at(input int idx);
        logic signed [ZW-1:0] r;
        r = '0;
        for (int k = 0; k < ATAN_LEN; k++) begin
            if (idx == k) r = ZW'(ATAN[k]);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_microrot.sv
`default_nettype none
// ============================================================================
// Module   : cordic_microrot
// Brief    : One combinational CORDIC vectoring micro-rotation. Rotates the
//            vector towards the positive x axis and accumulates the angle.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_microrot
    import cordic_pkg::*;
#(
    parameter int IW = 20,
    parameter int SW = 4
) (
    input  logic signed [IW-1:0] x_i,
    input  logic signed [IW-1:0] y_i,
    input  logic signed [ZW-1:0] z_i,
    input  logic        [SW-1:0] shift_i,
    input  logic signed [ZW-1:0] atan_i,
    output logic signed [IW-1:0] x_o,
    output logic signed [IW-1:0] y_o,
    output logic signed [ZW-1:0] z_o
);

    logic signed [IW-1:0] w_x_sh;
    logic signed [IW-1:0] w_y_sh;

    assign w_x_sh = x_i >>> shift_i;
    assign w_y_sh = y_i >>> shift_i;

    // Direction follows the sign of y so the residual angle is driven to zero
    always_comb begin
        if (!y_i[IW-1]) begin
            x_o = x_i + w_y_sh;
            y_o = y_i - w_x_sh;
            z_o = z_i + atan_i;
        end else begin
            x_o = x_i - w_y_sh;
            y_o = y_i + w_x_sh;
            z_o = z_i - atan_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cordic_atan2.sv
`default_nettype none
// ============================================================================
// Module   : cordic_atan2
// Brief    : Iterative CORDIC vectoring engine producing atan2(y,x) in
//            Q1.2.13 radians and a gain-compensated magnitude in Q1.1.14.
//            One sample in flight; valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module cordic_atan2
    import cordic_pkg::*;
#(
    parameter int ITER = ITER_DEFAULT,  // 12..14
    parameter int IW   = 20             // >= 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               valid_in,
    output logic               ready_in,
    input  logic signed [15:0] x_in,
    input  logic signed [15:0] y_in,
    output logic               valid_out,
    input  logic               ready_out,
    output logic signed [15:0] phase_out,
    output logic        [15:0] mag_out
);

    localparam int CW = $clog2(ITER);
    // Inputs need 18 signed bits after CORDIC gain; spare datapath bits are
    // used as fractional guard bits to keep truncation noise off the phase.
    localparam int GB     = IW - 18;
    localparam int PW     = IW + 16;
    localparam int MAG_SH = 14 + GB;

    localparam logic        [CW-1:0] C_LAST    = CW'(ITER - 1);
    localparam logic signed [ZW-1:0] C_HP_POS  = ZW'(HALF_PI);
    localparam logic signed [ZW-1:0] C_HP_NEG  = ZW'(-HALF_PI);
    localparam logic signed [ZW-1:0] C_PI_POS  = ZW'(PI);
    localparam logic signed [ZW-1:0] C_PI_NEG  = ZW'(-PI);
    localparam logic signed [15:0]   C_PH_MAX  = 16'(PI);
    localparam logic signed [15:0]   C_PH_MIN  = 16'(-PI);
    localparam logic signed [PW-1:0] C_KINV    = PW'(K_INV);
    localparam logic signed [PW-1:0] C_MAG_RND = PW'(1) <<< (MAG_SH - 1);
    localparam logic signed [PW-1:0] C_MAG_MAX = PW'(32767);

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic signed [IW-1:0] x_q;
    logic signed [IW-1:0] y_q;
    logic signed [ZW-1:0] z_q;
    logic signed [15:0]   phase_q;
    logic        [15:0]   mag_q;

    logic signed [IW-1:0] w_x_ext;
    logic signed [IW-1:0] w_y_ext;
    logic signed [IW-1:0] pre_x_d;
    logic signed [IW-1:0] pre_y_d;
    logic signed [ZW-1:0] pre_z_d;
    logic signed [IW-1:0] rot_x_d;
    logic signed [IW-1:0] rot_y_d;
    logic signed [ZW-1:0] rot_z_d;
    logic signed [ZW-1:0] w_atan;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_mag;
    logic signed [15:0]   phase_d;
    logic        [15:0]   mag_d;

    // Negation happens at IW bits so -(-32768) is representable
    assign w_x_ext = IW'(x_in) <<< GB;
    assign w_y_ext = IW'(y_in) <<< GB;

    // Fold left-half-plane inputs into the right half plane by +/-90 degrees
    always_comb begin
        pre_x_d = w_x_ext;
        pre_y_d = w_y_ext;
        pre_z_d = '0;
        if (x_in[15]) begin
            if (!y_in[15]) begin
                pre_x_d = w_y_ext;
                pre_y_d = -w_x_ext;
                pre_z_d = C_HP_POS;
            end else begin
                pre_x_d = -w_y_ext;
                pre_y_d = w_x_ext;
                pre_z_d = C_HP_NEG;
            end
        end
    end

    assign w_atan = atan_at(int'(cnt_q));

    cordic_microrot #(
        .IW (IW),
        .SW (CW)
    ) u_microrot (
        .x_i     (x_q),
        .y_i     (y_q),
        .z_i     (z_q),
        .shift_i (cnt_q),
        .atan_i  (w_atan),
        .x_o     (rot_x_d),
        .y_o     (rot_y_d),
        .z_o     (rot_z_d)
    );

    // Gain compensation with round-half-up, back to input scale
    assign w_prod = PW'(x_q) * C_KINV;
    assign w_mag  = (w_prod + C_MAG_RND) >>> MAG_SH;

    // Saturate results; an all-zero vector leaves z meaningless, so force 0
    always_comb begin
        mag_d   = w_mag[15:0];
        phase_d = z_q[15:0];
        if (w_mag[PW-1]) begin
            mag_d = '0;
        end else if (w_mag > C_MAG_MAX) begin
            mag_d = 16'h7FFF;
        end
        if (z_q > C_PI_POS) begin
            phase_d = C_PH_MAX;
        end else if (z_q < C_PI_NEG) begin
            phase_d = C_PH_MIN;
        end
        if (x_q == '0) begin
            mag_d   = '0;
            phase_d = '0;
        end
    end

    // Control FSM plus datapath registers; reset drops any in-flight sample
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            phase_q <= '0;
            mag_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_in) begin
                        x_q     <= pre_x_d;
                        y_q     <= pre_y_d;
                        z_q     <= pre_z_d;
                        cnt_q   <= '0;
                        state_q <= ROT;
                    end
                end
                ROT: begin
                    x_q <= rot_x_d;
                    y_q <= rot_y_d;
                    z_q <= rot_z_d;
                    if (cnt_q == C_LAST) begin
                        state_q <= SCALE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                SCALE: begin
                    phase_q <= phase_d;
                    mag_q   <= mag_d;
                    state_q <= DONE;
                end
                DONE: begin
                    if (ready_out) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_in  = (state_q == IDLE);
    assign valid_out = (state_q == DONE);
    assign phase_out = phase_q;
    assign mag_out   = mag_q;

endmodule
`default_nettype wire
